// File: rtl/mux_pack_if.sv
// Channel-side byte inputs and packed-word outputs of the decryption-path collector.
// The master drives select/channels and observes the word; the slave is mux_pack.
interface mux_pack_if #(
  parameter int MST_DWIDTH = 32,
  parameter int SYS_DWIDTH = 8
);
  logic [1:0]            select;
  logic [SYS_DWIDTH-1:0] data0_i;
  logic                  valid0_i;
  logic [SYS_DWIDTH-1:0] data1_i;
  logic                  valid1_i;
  logic [SYS_DWIDTH-1:0] data2_i;
  logic                  valid2_i;
  logic [MST_DWIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  drop_o;

  modport master (
    output select, data0_i, valid0_i, data1_i, valid1_i, data2_i, valid2_i,
    input  data_o, valid_o, drop_o
  );

  modport slave (
    input  select, data0_i, valid0_i, data1_i, valid1_i, data2_i, valid2_i,
    output data_o, valid_o, drop_o
  );
endinterface

// File: rtl/mux_pack.sv
// Packs four bytes from one locked decryption channel into a word, LSB first.
// Optional partial-word timeout is enabled by defining MUX_FLUSH_EN.
//
// state | meaning
// IDLE  | no bytes held, waiting for a byte on the selected channel
// B1    | 1 byte held, only the locked channel is accepted
// B2    | 2 bytes held
// B3    | 3 bytes held, next locked byte completes the word
module mux_pack #(
  parameter int MST_DWIDTH   = 32,
  parameter int SYS_DWIDTH   = 8,
  parameter int FLUSH_CYCLES = 16
) (
  input logic        clk_sys,
  input logic        rst,
  mux_pack_if.slave  bus
);

  if (MST_DWIDTH != 4 * SYS_DWIDTH) begin : g_bad_width
    $error("mux_pack: MST_DWIDTH must be 4 * SYS_DWIDTH");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 255) begin : g_bad_flush
    $error("mux_pack: FLUSH_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, B1, B2, B3} state_t;

  state_t                  state, state_n;
  logic [1:0]              lock, lock_n;
  logic [3*SYS_DWIDTH-1:0] held, held_n;
  logic [MST_DWIDTH-1:0]   word_n;
  logic                    load, drop_n;
  logic [SYS_DWIDTH-1:0]   data_arr [4];
  logic [3:0]              valid_vec, other_vec;
  logic                    sel_ok;

  // Index 3 is a permanently idle pseudo-channel so select = 3 needs no special path.
  assign data_arr[0] = bus.data0_i;
  assign data_arr[1] = bus.data1_i;
  assign data_arr[2] = bus.data2_i;
  assign data_arr[3] = '0;
  assign valid_vec   = {1'b0, bus.valid2_i, bus.valid1_i, bus.valid0_i};
  assign other_vec   = valid_vec & ~(4'b0001 << lock);
  assign sel_ok      = valid_vec[bus.select];

`ifdef MUX_FLUSH_EN
  localparam logic [7:0] FLUSH_LIM = 8'(FLUSH_CYCLES);
  logic [7:0] idle_cnt, idle_cnt_n;
`endif

  always_comb begin
    state_n = state;
    lock_n  = lock;
    held_n  = held;
    word_n  = '0;
    load    = 1'b0;
    drop_n  = 1'b0;
`ifdef MUX_FLUSH_EN
    idle_cnt_n = '0;
`endif
    if (state == IDLE) begin
      if (sel_ok) begin
        held_n[SYS_DWIDTH-1:0] = data_arr[bus.select];
        lock_n                 = bus.select;
        state_n                = B1;
      end
    end else begin
      drop_n = |other_vec;
      if (valid_vec[lock]) begin
        case (state)
          B1: begin
            held_n[SYS_DWIDTH +: SYS_DWIDTH] = data_arr[lock];
            state_n = B2;
          end
          B2: begin
            held_n[2*SYS_DWIDTH +: SYS_DWIDTH] = data_arr[lock];
            state_n = B3;
          end
          default: begin
            word_n  = {data_arr[lock], held};
            load    = 1'b1;
            held_n  = '0;
            state_n = IDLE;
          end
        endcase
      end else begin
`ifdef MUX_FLUSH_EN
        idle_cnt_n = idle_cnt + 8'd1;
        if (idle_cnt_n == FLUSH_LIM) begin
          held_n     = '0;
          state_n    = IDLE;
          drop_n     = 1'b1;
          idle_cnt_n = '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state       <= IDLE;
      lock        <= 2'd0;
      held        <= '0;
      bus.data_o  <= '0;
      bus.valid_o <= 1'b0;
      bus.drop_o  <= 1'b0;
    end else begin
      state       <= state_n;
      lock        <= lock_n;
      held        <= held_n;
      bus.valid_o <= load;
      bus.drop_o  <= drop_n;
      if (load) bus.data_o <= word_n;
    end
  end

`ifdef MUX_FLUSH_EN
  always_ff @(posedge clk_sys) begin
    if (rst) idle_cnt <= '0;
    else     idle_cnt <= idle_cnt_n;
  end
`endif

endmodule

// File: tb/tb_mux_pack.sv
// Self-checking bench for mux_pack: vector table, directed corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_mux_pack;
  localparam int FLUSH = 4;

  logic clk_sys = 1'b0;
  logic rst;
  int   vectors = 0;
  int   fails   = 0;

  always #5 clk_sys = ~clk_sys;

  mux_pack_if #(.MST_DWIDTH(32), .SYS_DWIDTH(8)) bus ();

  mux_pack #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .FLUSH_CYCLES(FLUSH)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  // Reference model: bytes held in a queue, word emitted once four have arrived.
  logic [7:0]  byte_q [$];
  int          m_lock = 0;
  int          m_idle = 0;
  logic [31:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_drop = 1'b0;

  task automatic model_step(input logic r, input logic [1:0] s, input logic [2:0] v,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] dd [3];
    dd[0] = a; dd[1] = b; dd[2] = c;
    m_valid = 1'b0;
    m_drop  = 1'b0;
    if (r) begin
      byte_q.delete();
      m_lock = 0; m_idle = 0; m_data = '0;
      return;
    end
    if (byte_q.size() == 0) begin
      if (s != 2'd3 && v[s]) begin
        byte_q.push_back(dd[s]);
        m_lock = int'(s);
        m_idle = 0;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++)
        if (ch != m_lock && v[ch]) m_drop = 1'b1;
      if (v[m_lock]) begin
        byte_q.push_back(dd[m_lock]);
        m_idle = 0;
        if (byte_q.size() == 4) begin
          m_data  = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
          m_valid = 1'b1;
          byte_q.delete();
        end
      end else begin
`ifdef MUX_FLUSH_EN
        m_idle++;
        if (m_idle == FLUSH) begin
          byte_q.delete();
          m_idle = 0;
          m_drop = 1'b1;
        end
`endif
      end
    end
  endtask

  task automatic apply(input logic r, input logic [1:0] s, input logic [2:0] v,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    rst          = r;
    bus.select   = s;
    bus.valid0_i = v[0];
    bus.valid1_i = v[1];
    bus.valid2_i = v[2];
    bus.data0_i  = a;
    bus.data1_i  = b;
    bus.data2_i  = c;
    @(posedge clk_sys);
    model_step(r, s, v, a, b, c);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] ed, input logic ev, input logic edr);
    vectors++;
    if (bus.data_o !== ed || bus.valid_o !== ev || bus.drop_o !== edr) begin
      fails++;
      $display("FAIL %s: got data=%h valid=%b drop=%b, want data=%h valid=%b drop=%b",
               nm, bus.data_o, bus.valid_o, bus.drop_o, ed, ev, edr);
    end
  endtask

  task automatic step_m(input string nm, input logic r, input logic [1:0] s, input logic [2:0] v,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    apply(r, s, v, a, b, c);
    chk(nm, m_data, m_valid, m_drop);
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  s;
    logic [2:0]  v;
    logic [7:0]  d0, d1, d2;
    logic        ev;
    logic        edr;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic [1:0] s, logic [2:0] v, logic [7:0] d0,
                              logic [7:0] d1, logic [7:0] d2, logic ev, logic edr,
                              logic [31:0] edata);
    vec_t t;
    t.r = r; t.s = s; t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.ev = ev; t.edr = edr; t.edata = edata;
    return t;
  endfunction

  initial begin
    rst = 1'b1;
    bus.select = 2'd3;
    bus.valid0_i = 1'b0; bus.valid1_i = 1'b0; bus.valid2_i = 1'b0;
    bus.data0_i = '0; bus.data1_i = '0; bus.data2_i = '0;

    // reset, select=3 noise, ch1 word, ch2 word with same-cycle foreign valids
    tbl.push_back(mk(1, 3, 3'b111, 8'h01, 8'h02, 8'h03, 0, 0, 32'h0));
    tbl.push_back(mk(0, 3, 3'b111, 8'h11, 8'h12, 8'h13, 0, 0, 32'h0));
    tbl.push_back(mk(0, 3, 3'b101, 8'h21, 8'h22, 8'h23, 0, 0, 32'h0));
    tbl.push_back(mk(0, 3, 3'b010, 8'h31, 8'h32, 8'h33, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h44, 8'h00, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h33, 8'h00, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h22, 8'h00, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3'b010, 8'h00, 8'h11, 8'h00, 1, 0, 32'h11223344));
    tbl.push_back(mk(0, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 32'h11223344));
    tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'hA1, 0, 0, 32'h11223344));
    tbl.push_back(mk(0, 2, 3'b100, 8'h00, 8'h00, 8'hB2, 0, 0, 32'h11223344));
    tbl.push_back(mk(0, 0, 3'b111, 8'hEE, 8'hFF, 8'hC3, 0, 1, 32'h11223344));
    tbl.push_back(mk(0, 0, 3'b100, 8'h00, 8'h00, 8'hD4, 1, 0, 32'hD4C3B2A1));
    tbl.push_back(mk(0, 3, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 32'hD4C3B2A1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      chk($sformatf("table[%0d]", i), tbl[i].edata, tbl[i].ev, tbl[i].edr);
    end

    // select change mid-word is ignored; gaps between bytes
    step_m("rst_a", 1, 3, 3'b000, 0, 0, 0);
    step_m("gap_b0", 0, 0, 3'b001, 8'hAA, 0, 0);
    for (int i = 0; i < 3; i++) step_m("gap_idle", 0, 0, 3'b000, 0, 0, 0);
    step_m("gap_b1", 0, 0, 3'b001, 8'hBB, 0, 0);
    for (int i = 0; i < 3; i++) step_m("gap_idle", 0, 0, 3'b000, 0, 0, 0);
    step_m("gap_b2", 0, 2, 3'b001, 8'hCC, 0, 0);
    step_m("gap_b3", 0, 2, 3'b001, 8'hDD, 0, 0);
    chk("gap_word", 32'hDDCCBBAA, 1'b1, 1'b0);

    // reset mid-word leaves no residue
    step_m("mid_b0", 0, 1, 3'b010, 0, 8'h5A, 0);
    step_m("mid_b1", 0, 1, 3'b010, 0, 8'h6B, 0);
    step_m("mid_rst", 1, 1, 3'b010, 0, 8'h7C, 0);
    chk("mid_rst_state", 32'h0, 1'b0, 1'b0);
    step_m("mid_n0", 0, 2, 3'b100, 0, 0, 8'h01);
    step_m("mid_n1", 0, 2, 3'b100, 0, 0, 8'h02);
    step_m("mid_n2", 0, 2, 3'b100, 0, 0, 8'h03);
    step_m("mid_n3", 0, 2, 3'b100, 0, 0, 8'h04);
    chk("mid_word", 32'h04030201, 1'b1, 1'b0);

    // back-to-back words
    for (int i = 1; i <= 8; i++) begin
      step_m("b2b", 0, 0, 3'b001, 8'(i), 0, 0);
      if (i == 4) chk("b2b_word0", 32'h04030201, 1'b1, 1'b0);
      if (i == 8) chk("b2b_word1", 32'h08070605, 1'b1, 1'b0);
    end
    step_m("b2b_after", 0, 0, 3'b000, 0, 0, 0);
    chk("b2b_pulse_end", 32'h08070605, 1'b0, 1'b0);

    // partial-word timeout, or indefinite wait without it
    step_m("fl_b0", 0, 0, 3'b001, 8'h01, 0, 0);
    step_m("fl_b1", 0, 0, 3'b001, 8'h02, 0, 0);
`ifdef MUX_FLUSH_EN
    for (int i = 1; i <= FLUSH; i++) begin
      step_m("fl_idle", 0, 0, 3'b000, 0, 0, 0);
      chk("fl_drop_timing", 32'h08070605, 1'b0, (i == FLUSH));
    end
`else
    for (int i = 0; i < 20; i++) step_m("hold_idle", 0, 0, 3'b000, 0, 0, 0);
    step_m("hold_b2", 0, 0, 3'b001, 8'h03, 0, 0);
    step_m("hold_b3", 0, 0, 3'b001, 8'h04, 0, 0);
    chk("hold_word", 32'h04030201, 1'b1, 1'b0);
`endif
    step_m("fw0", 0, 0, 3'b001, 8'h10, 0, 0);
    step_m("fw1", 0, 0, 3'b001, 8'h20, 0, 0);
    step_m("fw2", 0, 0, 3'b001, 8'h30, 0, 0);
    step_m("fw3", 0, 0, 3'b001, 8'h40, 0, 0);
    chk("fw_word", 32'h40302010, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] v;
      v[0] = ($urandom_range(0, 2) == 0);
      v[1] = ($urandom_range(0, 2) == 0);
      v[2] = ($urandom_range(0, 2) == 0);
      step_m("rand", ($urandom_range(0, 149) == 0), 2'($urandom_range(0, 3)), v,
             8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/mux_pack.md
# mux_pack

Collector at the output side of the decryption path. Gathers SYS_DWIDTH-bit bytes from one of three decryption channels (chosen by `select`) and packs four consecutive bytes, least-significant first, into one MST_DWIDTH-bit word with a one-cycle valid pulse. It is the inverse of the word-to-byte splitter that feeds the channels, and runs on the system clock.

## Interface
- MST_DWIDTH, 32, output word width; fixed at 4 × SYS_DWIDTH
- SYS_DWIDTH, 8, channel byte width
- FLUSH_CYCLES, 16, idle-cycle limit for a partial word; used only with MUX_FLUSH_EN; legal range 1..255
- clk_sys  input  1  system clock; all logic on its rising edge
- rst  input  1  reset; synchronous, active-high
- select  input  2  channel select: 0, 1 or 2; 3 selects no channel
- data0_i / valid0_i  input  SYS_DWIDTH / 1  channel 0 byte and qualifier
- data1_i / valid1_i  input  SYS_DWIDTH / 1  channel 1 byte and qualifier
- data2_i / valid2_i  input  SYS_DWIDTH / 1  channel 2 byte and qualifier
- data_o  output  MST_DWIDTH  packed word, registered
- valid_o  output  1  one-cycle pulse; data_o is valid
- drop_o  output  1  one-cycle pulse; a byte or partial word was discarded

## Operation
- State machine: IDLE (0 bytes held), B1, B2, B3 (1, 2 or 3 bytes held); 2-bit locked-channel register `lock`.
- IDLE: `select` in 0..2 and `valid[select]` high → accept the byte into [7:0], latch `lock = select`, go to B1. Sampling `select` = 3 accepts nothing. Valids on unselected channels are ignored without a drop.
- B1/B2/B3: only `valid[lock]` is accepted; `select` is ignored until the word completes. The byte goes into [15:8], [23:16] or [31:24]. The state advances B1→B2→B3.
- B3 accepting its byte: load the assembled word into data_o, pulse valid_o, return to IDLE, clear held bytes.
- In B1..B3, a high valid on a channel other than `lock` drops that byte and pulses drop_o. Several such channels in one cycle give a single pulse.
- A byte on `lock` is accepted in the same cycle as a drop on another channel.
- data_o holds the last word until the next completes; it is never partially updated.
- Valid qualifiers are single-cycle per byte. A held-high valid counts as one byte per cycle.

## Timing
- Reset values: data_o = 0, valid_o = 0, drop_o = 0, state IDLE, lock = 0, held bytes = 0.
- Reset asserted mid-word discards the partial word with no drop_o pulse. Reset has priority over any valid in the same cycle.
- Latency: 4th byte sampled at edge N → data_o and valid_o visible after edge N (registered, 1 cycle), valid_o low after edge N+1.
- Back-to-back: byte 0 of the next word may arrive on the cycle right after the 4th byte. Peak throughput is one word per 4 cycles.
- drop_o is registered and high for the one cycle after the offending edge.
- Gaps between bytes of a word are unbounded unless MUX_FLUSH_EN is defined.

## Configuration
- MUX_FLUSH_EN defined:
  - An 8-bit idle counter runs in B1..B3. It clears on every accepted byte and on entry to B1.
  - When it reaches FLUSH_CYCLES consecutive cycles with no accepted byte, the partial word is discarded, the state returns to IDLE, and drop_o pulses once. data_o is unchanged and valid_o is not asserted.
  - A byte accepted on the cycle the limit is reached wins: it is accepted and no flush occurs.
- MUX_FLUSH_EN undefined: no counter; a partial word waits indefinitely; FLUSH_CYCLES has no effect.

## Test plan
- select = 1; valid1_i pulses on 4 consecutive cycles with bytes 0x44, 0x33, 0x22, 0x11 → one valid_o pulse one cycle after the last byte, data_o = 0x11223344, drop_o stays 0.
- select = 0; bytes 0xAA, 0xBB with 3-cycle gaps, then select → 2 and channel 0 sends 0xCC, 0xDD → data_o = 0xDDCCBBAA. The change of select is ignored while the word is in progress.
- Lock on channel 2; after byte 1, valid0_i and valid1_i are high in the same cycle as valid2_i → drop_o pulses once, the channel-2 byte is accepted, and the word completes normally.
- select = 3 with all valids toggling → no valid_o, no drop_o, data_o stays 0. After reset mid-word (2 bytes held), a new 4-byte word completes with correct value and no residue.
- Two words back-to-back (8 consecutive valid cycles, bytes 0x01..0x08) → valid_o pulses at cycle 5 (data_o = 0x04030201) and cycle 9 (data_o = 0x08070605).
- MUX_FLUSH_EN, FLUSH_CYCLES = 4: send 2 bytes, then idle → drop_o pulses 4 cycles after the last byte, with no valid_o. A following full word of 0x10, 0x20, 0x30, 0x40 gives data_o = 0x40302010.
